pixel_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that drives the edge-detect core's window input (pixel_1_bin..pixel_9_bin, start). It accepts a raster-order pixel stream, one pixel per valid cycle, buffers the two previous image lines, and emits each complete interior 3x3 window with a one-cycle start pulse. It sits between the frame source (memory reader or camera front end) and the edge-detect core.

---
 rtl/edge_pkg.sv | 18 +
 rtl/pixel_line_buffer.sv | 27 ++
 rtl/pixel_window_gen.sv | 164 ++++++++++++++++
 tb/tb_pixel_window_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types for the edge-detect pipeline: pixel width, pixel and 3x3 window
// types, and the window generator's control states.
package edge_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Row-major 3x3 neighbourhood: 1 = top-left, 5 = centre, 9 = bottom-right.
  typedef pixel_t window_t [1:9];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } win_state_t;

endpackage

// File: rtl/pixel_line_buffer.sv
// One image line of pixel storage: a single write port and an asynchronous
// read at the same address, so old data is visible in the cycle it is replaced.
module pixel_line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  // Contents are intentionally not reset; every entry is rewritten before use.
  pixel_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pixel_window_gen.sv
// Streaming 3x3 window generator: buffers two lines of a raster pixel stream
// and emits every interior neighbourhood with a one-cycle start pulse.
module pixel_window_gen
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] pixel_1_bin,
  output logic [PIX_W-1:0] pixel_2_bin,
  output logic [PIX_W-1:0] pixel_3_bin,
  output logic [PIX_W-1:0] pixel_4_bin,
  output logic [PIX_W-1:0] pixel_5_bin,
  output logic [PIX_W-1:0] pixel_6_bin,
  output logic [PIX_W-1:0] pixel_7_bin,
  output logic [PIX_W-1:0] pixel_8_bin,
  output logic [PIX_W-1:0] pixel_9_bin,
  output logic             start,
  output logic             busy,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  win_state_t       state_reg, state_next;
  logic             start_reg, start_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic             col_is_last, row_is_last, win_complete;

  pixel_t  lb_a_rd, lb_b_rd;
  pixel_t  col_new [0:2];
  pixel_t  win_reg [0:2][0:2];
  window_t out_reg;

  assign col_is_last  = (col_reg == COL_LAST);
  assign row_is_last  = (row_reg == ROW_LAST);
  assign win_complete = pix_valid && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

  // lb_a holds line r-2, lb_b line r-1; lb_a is refilled from lb_b's old value.
  pixel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb_a (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (col_reg),
    .wdata (lb_b_rd),
    .rdata (lb_a_rd)
  );

  pixel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_lb_b (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (col_reg),
    .wdata (pix_in),
    .rdata (lb_b_rd)
  );

  assign col_new[0] = lb_a_rd;
  assign col_new[1] = lb_b_rd;
  assign col_new[2] = pix_in;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (pix_valid) begin
      if (col_is_last) begin
        col_next = '0;
        row_next = row_is_last ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    start_next      = 1'b0;
    frame_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pix_valid) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (pix_valid && (row_reg == ROW_W'(1)) && col_is_last) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        start_next = win_complete;
        if (pix_valid && row_is_last && col_is_last) begin
          frame_done_next = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg        <= '0;
      row_reg        <= '0;
      state_reg      <= ST_IDLE;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      state_reg      <= state_next;
      start_reg      <= start_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // New column enters from the right; the output copy includes that column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_reg[i][j] <= '0;
        end
      end
      for (int k = 1; k <= 9; k++) begin
        out_reg[k] <= '0;
      end
    end else if (pix_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_reg[i][0] <= win_reg[i][1];
        win_reg[i][1] <= win_reg[i][2];
        win_reg[i][2] <= col_new[i];
      end
      if (start_next) begin
        for (int i = 0; i < 3; i++) begin
          out_reg[3*i+1] <= win_reg[i][1];
          out_reg[3*i+2] <= win_reg[i][2];
          out_reg[3*i+3] <= col_new[i];
        end
      end
    end
  end

  assign pixel_1_bin = out_reg[1];
  assign pixel_2_bin = out_reg[2];
  assign pixel_3_bin = out_reg[3];
  assign pixel_4_bin = out_reg[4];
  assign pixel_5_bin = out_reg[5];
  assign pixel_6_bin = out_reg[6];
  assign pixel_7_bin = out_reg[7];
  assign pixel_8_bin = out_reg[8];
  assign pixel_9_bin = out_reg[9];
  assign start       = start_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Directed bench for pixel_window_gen on a 5x4 frame with p(r,c) = r*5 + c;
// windows are checked against centres (1..2, 1..3) in raster order.
module tb_pixel_window_gen;

  localparam int W = 5;
  localparam int H = 4;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic [7:0] pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin, pixel_5_bin;
  logic [7:0] pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin;
  logic       start, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int win_count;
  int fd_count;
  int off_step;
  bit b2b_mode;
  logic        last_valid;
  logic [71:0] exp_hold;

  always #5 clk = ~clk;

  pixel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pixel_1_bin (pixel_1_bin),
    .pixel_2_bin (pixel_2_bin),
    .pixel_3_bin (pixel_3_bin),
    .pixel_4_bin (pixel_4_bin),
    .pixel_5_bin (pixel_5_bin),
    .pixel_6_bin (pixel_6_bin),
    .pixel_7_bin (pixel_7_bin),
    .pixel_8_bin (pixel_8_bin),
    .pixel_9_bin (pixel_9_bin),
    .start       (start),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window centred at (1 + idx/3, 1 + idx%3), pixels offset by off.
  function automatic logic [71:0] exp_win(input int idx, input int off);
    logic [71:0] v;
    int rc, cc;
    v  = '0;
    rc = 1 + idx / (W - 2);
    cc = 1 + idx % (W - 2);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = {v[63:0], 8'((rc - 1 + i) * W + (cc - 1 + j) + off)};
      end
    end
    return v;
  endfunction

  function automatic logic [71:0] win_vec();
    return {pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin, pixel_5_bin,
            pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin};
  endfunction

  task automatic sample();
    logic [71:0] e;
    logic [71:0] v;
    v = win_vec();
    if (start) begin
      e = exp_win(win_count % NWIN, (win_count / NWIN) * off_step);
      check("start_after_accept", 72'(last_valid), 72'(1));
      check("window", v, e);
      check("frame_done_on_last", 72'(frame_done), 72'((win_count % NWIN) == NWIN - 1));
      if (win_count == 0) check("first_window", v, 72'h00_01_02_05_06_07_0a_0b_0c);
      if (b2b_mode && win_count == NWIN) check("f2_centre", 72'(pixel_5_bin), 72'(106));
      $display("start #%0d window=%0h frame_done=%0b", win_count, v, frame_done);
      exp_hold = e;
      if (frame_done) fd_count++;
      win_count++;
    end else begin
      check("hold", v, exp_hold);
      check("frame_done_idle", 72'(frame_done), 72'(0));
    end
  endtask

  task automatic step(input logic v, input int p);
    @(negedge clk);
    sample();
    last_valid = v && !reset;
    pix_valid  = v;
    pix_in     = 8'(p);
  endtask

  task automatic feed_frame(input int off, input bit gaps);
    for (int k = 0; k < W * H; k++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          step(1'b0, 0);
          if (k > 0) check("busy_gap", 72'(busy), 72'(1));
        end
      end
      step(1'b1, off + k);
      if (k > 0) check("busy_mid", 72'(busy), 72'(1));
    end
  endtask

  task automatic new_scenario(input int step_off, input bit b2b);
    win_count = 0;
    fd_count  = 0;
    off_step  = step_off;
    b2b_mode  = b2b;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_start"}, 72'(start), 72'(0));
    check({tag, "_busy"}, 72'(busy), 72'(0));
    check({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    check({tag, "_window"}, win_vec(), 72'(0));
  endtask

  initial begin
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_in     = '0;
    last_valid = 1'b0;
    exp_hold   = '0;
    new_scenario(0, 1'b0);

    // Reset state, then idle with no valid input
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (4) begin
      step(1'b0, 0);
      check_zero_outputs("idle");
    end

    // Continuous frame
    new_scenario(0, 1'b0);
    feed_frame(0, 1'b0);
    repeat (3) step(1'b0, 0);
    check("cont_nwin", 72'(win_count), 72'(NWIN));
    check("cont_nfd", 72'(fd_count), 72'(1));
    check("cont_last_centre", 72'(pixel_5_bin), 72'(13));
    check("cont_busy_after", 72'(busy), 72'(0));

    // Same frame with random valid gaps
    new_scenario(0, 1'b0);
    feed_frame(0, 1'b1);
    repeat (3) step(1'b0, 0);
    check("gap_nwin", 72'(win_count), 72'(NWIN));
    check("gap_nfd", 72'(fd_count), 72'(1));

    // Two back-to-back frames, second offset by 100
    new_scenario(100, 1'b1);
    feed_frame(0, 1'b0);
    feed_frame(100, 1'b0);
    repeat (3) step(1'b0, 0);
    check("b2b_nwin", 72'(win_count), 72'(2 * NWIN));
    check("b2b_nfd", 72'(fd_count), 72'(2));
    check("b2b_busy_after", 72'(busy), 72'(0));

    // Reset after pixel (2,3), then a clean frame
    new_scenario(0, 1'b0);
    for (int k = 0; k <= 2 * W + 3; k++) step(1'b1, k);
    step(1'b0, 0);
    check("pre_reset_nwin", 72'(win_count), 72'(2));
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    exp_hold   = '0;
    last_valid = 1'b0;
    repeat (2) begin
      step(1'b0, 0);
      check_zero_outputs("mid_reset_hold");
    end
    @(negedge clk);
    reset = 1'b0;
    new_scenario(0, 1'b0);
    feed_frame(0, 1'b0);
    repeat (3) step(1'b0, 0);
    check("post_reset_nwin", 72'(win_count), 72'(NWIN));
    check("post_reset_nfd", 72'(fd_count), 72'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
